// File: rtl/simon_seq_ctrl_pkg.sv
// Shared types and helpers for the Simon round sequencer.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_IN, GAP, WIN, LOSE
    } state_t;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] GRN = 2'd1;
    localparam logic [1:0] BLU = 2'd2;
    localparam logic [1:0] YEL = 2'd3;

    // Width needed to hold a sequence length of 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/simon_seq_ctrl_if.sv
// Game-side signals of the sequencer: timing, buttons, LFSR and LED/display.
interface simon_seq_ctrl_if #(parameter int MAX_LEN = 16);
    import simon_pkg::*;
    localparam int LEN_W = len_w(MAX_LEN);

    logic             tick;
    logic             start;
    logic             btn_valid;
    logic [1:0]       btn_code;
    logic [1:0]       lfsr_q;
    logic             lfsr_en;
    logic             led_on;
    logic [1:0]       led_code;
    logic [LEN_W-1:0] level;
    logic             busy;
    logic             win;
    logic             lose;

    modport master (
        output tick, start, btn_valid, btn_code, lfsr_q,
        input  lfsr_en, led_on, led_code, level, busy, win, lose
    );

    modport slave (
        input  tick, start, btn_valid, btn_code, lfsr_q,
        output lfsr_en, led_on, led_code, level, busy, win, lose
    );
endinterface

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: one synchronous write port, one asynchronous read port.
module simon_seq_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);
    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon round sequencer: grows the colour sequence, plays it back, then
// checks the player's presses against it.
module simon_seq_ctrl import simon_pkg::*; #(
    parameter int MAX_LEN       = 16,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    simon_seq_ctrl_if.slave bus
);
    localparam int LEN_W   = len_w(MAX_LEN);
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int M1      = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int M2      = (M1 > GAP_TICKS) ? M1 : GAP_TICKS;
    localparam int CNT_MAX = (M2 > TIMEOUT_TICKS) ? M2 : TIMEOUT_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cur;
    logic             idx_last;

    // ADD always runs with len < MAX_LEN, so len is a valid write address there.
    simon_seq_mem #(.DEPTH(MAX_LEN), .AW(IDX_W)) u_mem (
        .clk   (clk),
        .we    (state == ADD),
        .waddr (IDX_W'(len)),
        .wdata (bus.lfsr_q),
        .raddr (idx),
        .rdata (cur)
    );

    assign idx_last = (LEN_W'(idx) == len - LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: if (bus.start) begin
                    len   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    len   <= len + LEN_W'(1);
                    idx   <= '0;
                    cnt   <= '0;
                    state <= PLAY_ON;
                end
                PLAY_ON: if (bus.tick) begin
                    if (cnt == ON_LAST) begin
                        cnt   <= '0;
                        state <= PLAY_OFF;
                    end else cnt <= cnt + CNT_W'(1);
                end
                PLAY_OFF: if (bus.tick) begin
                    if (cnt == OFF_LAST) begin
                        cnt <= '0;
                        if (idx_last) begin
                            idx   <= '0;
                            state <= WAIT_IN;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= PLAY_ON;
                        end
                    end else cnt <= cnt + CNT_W'(1);
                end
                WAIT_IN: begin
                    // A press always wins over a coincident timeout tick.
                    if (bus.btn_valid) begin
                        if (bus.btn_code != cur) state <= LOSE;
                        else if (idx_last) begin
                            cnt   <= '0;
                            state <= (len == LEN_MAX) ? WIN : GAP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            cnt <= '0;
                        end
                    end else if (bus.tick) begin
                        if (cnt == TO_LAST) state <= LOSE;
                        else cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: if (bus.tick) begin
                    if (cnt == GAP_LAST) state <= ADD;
                    else cnt <= cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led_on   = (state == PLAY_ON);
    assign bus.led_code = (state == PLAY_ON) ? cur : RED;
    assign bus.lfsr_en  = (state inside {IDLE, ADD, WIN, LOSE});
    assign bus.busy     = !(state inside {IDLE, WIN, LOSE});
    assign bus.win      = (state == WIN);
    assign bus.lose     = (state == LOSE);
    assign bus.level    = len;
endmodule
